stopwatch_controller: RTL and testbench

Sequences the stopwatch time base that feeds the 640x480 time-display drawer (hours 0-9, minutes, seconds, milliseconds).
- Runs a millisecond prescaler and a cascaded ms/s/min/h counter chain.
- A run/pause/clear FSM driven by single-cycle button pulses controls the chain.
- Display values change only at frame boundaries, so the drawer never shows a torn value mid-frame.

---
 rtl/stopwatch_pkg.sv | 28 ++
 rtl/stopwatch_controller_mod_counter.sv | 30 +++
 rtl/stopwatch_controller.sv | 171 +++++++++++++++++
 tb/tb_stopwatch_controller.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch time base: FSM encoding, field widths and field limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_SAT   = 2'd3
    } state_t;

    localparam int HOURS_W = 4;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int MS_W    = 10;

    localparam int MS_MAX  = 999;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    // Snapshot of one displayed time value, hours in the top bits.
    typedef struct packed {
        logic [HOURS_W-1:0] hours;
        logic [MIN_W-1:0]   minutes;
        logic [SEC_W-1:0]   seconds;
        logic [MS_W-1:0]    milliseconds;
    } time_t;

endpackage

// File: rtl/stopwatch_controller_mod_counter.sv
// Modulo-N counter with increment enable, carry-out, hold and synchronous clear.
module mod_counter
    import stopwatch_pkg::*;
#(
    parameter int N = 10,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc_en,
    input  logic         hold,
    output logic [W-1:0] count,
    output logic         carry_out
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    // Carry does not depend on hold, so hold may be derived from the chain carry without a loop.
    assign carry_out = inc_en && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc_en && !hold) begin
            count <= carry_out ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch time base: ms prescaler, cascaded ms/s/min/h counters, run/pause/clear FSM, frame-synced display.
// Optional lap freeze of the display is enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int TICK_DIV    = CLK_FREQ_HZ / 1000,
    parameter int MAX_HOURS   = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_stop,
    input  logic               clear,
    input  logic               lap,
    input  logic               frame_start,
    output logic [HOURS_W-1:0] hours,
    output logic [MIN_W-1:0]   minutes,
    output logic [SEC_W-1:0]   seconds,
    output logic [MS_W-1:0]    milliseconds,
    output logic               running,
    output logic               overflow
);

    localparam int            PW        = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    state_t             state;
    logic [PW-1:0]      presc;
    logic               tick;
    logic               terminal;
    logic               lap_hold;

    logic [MS_W-1:0]    ms_count;
    logic [SEC_W-1:0]   sec_count;
    logic [MIN_W-1:0]   min_count;
    logic [HOURS_W-1:0] hour_count;
    logic               ms_carry;
    logic               sec_carry;
    logic               min_carry;
    logic               hour_carry;

    assign tick     = (state == ST_RUN) && (presc == TICK_LAST);
    // Carry out of the hours stage means this tick would wrap MAX_HOURS:59:59.999.
    assign terminal = hour_carry;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            presc <= '0;
        end else if (state == ST_RUN) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state    <= ST_IDLE;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_stop) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (terminal) begin
                        state    <= ST_SAT;
                        running  <= 1'b0;
                        overflow <= 1'b1;
                    end else if (start_stop) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_SAT: begin
                    overflow <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    running  <= 1'b0;
                    overflow <= 1'b0;
                end
            endcase
        end
    end

    mod_counter #(.N(MS_MAX + 1), .W(MS_W)) u_ms (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .inc_en    (tick),
        .hold      (terminal),
        .count     (ms_count),
        .carry_out (ms_carry)
    );

    mod_counter #(.N(SEC_MAX + 1), .W(SEC_W)) u_sec (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .inc_en    (ms_carry),
        .hold      (terminal),
        .count     (sec_count),
        .carry_out (sec_carry)
    );

    mod_counter #(.N(MIN_MAX + 1), .W(MIN_W)) u_min (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .inc_en    (sec_carry),
        .hold      (terminal),
        .count     (min_count),
        .carry_out (min_carry)
    );

    mod_counter #(.N(MAX_HOURS + 1), .W(HOURS_W)) u_hours (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .inc_en    (min_carry),
        .hold      (terminal),
        .count     (hour_count),
        .carry_out (hour_carry)
    );

`ifdef STOPWATCH_LAP_HOLD_EN
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lap_hold <= 1'b0;
        end else if (lap && !start_stop && (state == ST_RUN)) begin
            lap_hold <= !lap_hold;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_hold   = 1'b0;
`endif

    // A clear in the same cycle as frame_start loads zero, so the drawer never sees stale time.
    always_ff @(posedge clk) begin
        if (reset) begin
            hours        <= '0;
            minutes      <= '0;
            seconds      <= '0;
            milliseconds <= '0;
        end else if (frame_start && (clear || !lap_hold)) begin
            if (clear) begin
                hours        <= '0;
                minutes      <= '0;
                seconds      <= '0;
                milliseconds <= '0;
            end else begin
                hours        <= hour_count;
                minutes      <= min_count;
                seconds      <= sec_count;
                milliseconds <= ms_count;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_controller.sv
// Self-checking bench for stopwatch_controller with a 4-clock millisecond tick.
// Lap expectations follow STOPWATCH_LAP_HOLD_EN when the bench is built with it.
module tb_stopwatch_controller;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic       frame_start = 1'b0;
    logic [3:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic [9:0] milliseconds;
    logic       running;
    logic       overflow;

    logic [27:0] exp_q[$];
    logic [27:0] exp_v;
    logic [27:0] obs;
    int          n_checks = 0;
    int          n_fail = 0;

    assign obs = {hours, minutes, seconds, milliseconds, running, overflow};

    stopwatch_controller #(
        .CLK_FREQ_HZ (4000),
        .TICK_DIV    (TICK_DIV),
        .MAX_HOURS   (9)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_stop   (start_stop),
        .clear        (clear),
        .lap          (lap),
        .frame_start  (frame_start),
        .hours        (hours),
        .minutes      (minutes),
        .seconds      (seconds),
        .milliseconds (milliseconds),
        .running      (running),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time %0t exceeded bound", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [27:0] pk(int h, int m, int s, int ms, logic r, logic o);
        return {4'(h), 6'(m), 6'(s), 10'(ms), r, o};
    endfunction

    // Driver tasks: called at a negedge, hold the input over one posedge, return at the next negedge.
    task automatic pulse_start();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1;
        @(negedge clk);
        lap = 1'b0;
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start_stop = 1'b1;
        frame_start = 1'b1;
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
        idle(3);
        reset = 1'b0;
        start_stop = 1'b0;
        frame_start = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", obs, exp_v);
        end
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
        idle(8);
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_stays_idle: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_run();
        pulse_start();
        exp_q.push_back(pk(0, 0, 1, 0, 1, 0));
        idle(1000 * TICK_DIV);
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL run_1s: got %h expected %h", obs, exp_v);
        end
        exp_q.push_back(pk(0, 0, 1, 0, 1, 0));
        idle(40);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL display_hold: got %h expected %h", obs, exp_v);
        end
        exp_q.push_back(pk(0, 0, 1, 10, 1, 0));
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL run_reload: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_pause();
        pulse_clear();
        pulse_start();
        idle(10 * TICK_DIV + 2);
        pulse_start();
        exp_q.push_back(pk(0, 0, 0, 10, 0, 0));
        idle(100);
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL pause_hold: got %h expected %h", obs, exp_v);
        end
        pulse_start();
        exp_q.push_back(pk(0, 0, 0, 10, 1, 0));
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL tick_with_frame: got %h expected %h", obs, exp_v);
        end
        exp_q.push_back(pk(0, 0, 0, 12, 1, 0));
        idle(TICK_DIV);
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL resume_partial: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_carry();
        pulse_clear();
        pulse_start();
        pulse_start();
        force dut.u_ms.count = 10'd999;
        force dut.u_sec.count = 6'd59;
        force dut.u_min.count = 6'd59;
        force dut.u_hours.count = 4'd0;
        #1;
        release dut.u_ms.count;
        release dut.u_sec.count;
        release dut.u_min.count;
        release dut.u_hours.count;
        pulse_start();
        exp_q.push_back(pk(1, 0, 0, 0, 1, 0));
        idle(3);
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL carry_chain: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_saturate();
        pulse_clear();
        pulse_start();
        pulse_start();
        force dut.u_ms.count = 10'd999;
        force dut.u_sec.count = 6'd59;
        force dut.u_min.count = 6'd59;
        force dut.u_hours.count = 4'd9;
        #1;
        release dut.u_ms.count;
        release dut.u_sec.count;
        release dut.u_min.count;
        release dut.u_hours.count;
        pulse_start();
        exp_q.push_back(pk(9, 59, 59, 999, 0, 1));
        idle(3);
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL saturate: got %h expected %h", obs, exp_v);
        end
        pulse_start();
        exp_q.push_back(pk(9, 59, 59, 999, 0, 1));
        idle(20);
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL sat_ignores_start: got %h expected %h", obs, exp_v);
        end
        pulse_clear();
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL sat_clear: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_clear_priority();
        pulse_clear();
        pulse_start();
        exp_q.push_back(pk(0, 0, 0, 5, 1, 0));
        idle(5 * TICK_DIV);
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL pre_clear_count: got %h expected %h", obs, exp_v);
        end
        clear = 1'b1;
        start_stop = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        start_stop = 1'b0;
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL clear_over_start: got %h expected %h", obs, exp_v);
        end
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
        idle(20);
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL idle_after_clear: got %h expected %h", obs, exp_v);
        end
        pulse_start();
        idle(5 * TICK_DIV);
        frame();
        clear = 1'b1;
        frame_start = 1'b1;
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        clear = 1'b0;
        frame_start = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL clear_with_frame: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        exp_q.push_back(pk(0, 0, 0, 3, 1, 0));
        idle(3 * TICK_DIV);
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL pre_reset_count: got %h expected %h", obs, exp_v);
        end
        reset = 1'b1;
        frame_start = 1'b1;
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        frame_start = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset_mid_run: got %h expected %h", obs, exp_v);
        end
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0));
        idle(8);
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_lap();
        pulse_clear();
        pulse_start();
        exp_q.push_back(pk(0, 0, 0, 50, 1, 0));
        idle(50 * TICK_DIV);
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL lap_start_value: got %h expected %h", obs, exp_v);
        end
        pulse_lap();
`ifdef STOPWATCH_LAP_HOLD_EN
        exp_q.push_back(pk(0, 0, 0, 50, 1, 0));
`else
        exp_q.push_back(pk(0, 0, 0, 150, 1, 0));
`endif
        idle(100 * TICK_DIV - 2);
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL lap_frozen: got %h expected %h", obs, exp_v);
        end
        pulse_lap();
        exp_q.push_back(pk(0, 0, 0, 150, 1, 0));
        frame();
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL lap_release: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_run();
        test_pause();
        test_carry();
        test_saturate();
        test_clear_priority();
        test_reset_mid_run();
        test_lap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
